tdc_launch_ctrl: RTL and testbench

Sequencer for the TDC pulse generator. Latches a launch configuration, then issues a programmed burst of launch events by driving the generator's enable, toggle, source-select and bypass controls. Emits a delayed capture strobe per launch for the sampling chain and signals completion. Sits between the host/config interface and the pulse generator, all in the clk_launch domain.

---
 rtl/tdc_pkg.sv | 7 +
 rtl/tdc_launch_ctrl_if.sv | 29 ++
 rtl/tdc_cap_delay.sv | 30 +++
 rtl/tdc_launch_ctrl.sv | 123 ++++++++++++
 tb/tb_tdc_launch_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// Shared TDC encodings: pulse-generator source/path selects and launch sequencer states.
package tdc_pkg;
    typedef enum logic { PG_IN  = 1'b0, PG_TOG = 1'b1 } pg_src_t;
    typedef enum logic { BYPASS = 1'b0, REG    = 1'b1 } pg_path_t;
    typedef enum logic [1:0] { IDLE, LAUNCH, GAP, DRAIN } launch_state_t;
    localparam int CAP_LAT_MAX = 15;
endpackage

// File: rtl/tdc_launch_ctrl_if.sv
// Host config / pulse-generator control bundle for the launch sequencer.
interface tdc_launch_ctrl_if #(parameter int CNT_W = 8, parameter int GAP_W = 8);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_num;
    logic [GAP_W-1:0] cfg_gap;
    logic             cfg_src;
    logic             cfg_bypass;
    logic             start;
    logic             abort;
    logic             pg_en;
    logic             pg_tog;
    logic             pg_src;
    logic             pg_bypass;
    logic             cap_strobe;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] launch_cnt;

    modport master (
        output cfg_valid, cfg_num, cfg_gap, cfg_src, cfg_bypass, start, abort,
        input  cfg_ready, pg_en, pg_tog, pg_src, pg_bypass, cap_strobe, busy, done, aborted, launch_cnt
    );
    modport slave (
        input  cfg_valid, cfg_num, cfg_gap, cfg_src, cfg_bypass, start, abort,
        output cfg_ready, pg_en, pg_tog, pg_src, pg_bypass, cap_strobe, busy, done, aborted, launch_cnt
    );
endinterface

// File: rtl/tdc_cap_delay.sv
// Fixed-latency strobe delay: shift register with synchronous clear.
module tdc_cap_delay #(parameter int LAT = 3) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_in,
    output logic o_strobe,
    output logic o_idle_next
);
    localparam logic [LAT-1:0] OUT_BIT = LAT'(1) << (LAT - 1);

    logic [LAT-1:0] r_sr;
    logic [LAT-1:0] w_rest;

    // Nothing but the output stage occupied and nothing entering: empty after this edge.
    assign w_rest      = r_sr & ~OUT_BIT;
    assign o_strobe    = r_sr[LAT-1];
    assign o_idle_next = (w_rest == '0) && !i_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_in;
            for (int k = 1; k < LAT; k++) r_sr[k] <= r_sr[k-1];
        end
    end
endmodule

// File: rtl/tdc_launch_ctrl.sv
// Launch sequencer: latches a burst config, drives the pulse generator, delays capture strobes.
import tdc_pkg::*;

module tdc_launch_ctrl #(
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 8,
    parameter int CAP_LAT = 3
) (
    input  logic              clk_launch,
    input  logic              rst_n,
    tdc_launch_ctrl_if.slave  bus
);
    localparam int LAT = (CAP_LAT > CAP_LAT_MAX) ? CAP_LAT_MAX : ((CAP_LAT < 1) ? 1 : CAP_LAT);

    launch_state_t    r_state, w_next;
    logic [CNT_W-1:0] r_cfg_num, r_run_num, r_cnt;
    logic [GAP_W-1:0] r_cfg_gap, r_run_gap, r_gap_cnt;
    logic             r_cfg_src, r_cfg_byp, r_pg_src, r_pg_byp;
    logic             r_tog, r_done, r_aborted;
    logic             w_start_go, w_done_set, w_abort_go;
    logic             w_cfg_xfer, w_launch, w_pipe_idle_next, w_strobe;

    assign w_cfg_xfer = bus.cfg_valid && (r_state == IDLE);
    assign w_launch   = (r_state == LAUNCH);

    always_comb begin
        w_next     = r_state;
        w_start_go = 1'b0;
        w_done_set = 1'b0;
        w_abort_go = 1'b0;
        case (r_state)
            IDLE: if (bus.start && !bus.abort) begin
                w_start_go = 1'b1;
                if (r_cfg_num == '0) w_done_set = 1'b1;
                else                 w_next     = LAUNCH;
            end
            LAUNCH: begin
                if (r_cnt + 1'b1 == r_run_num) w_next = DRAIN;
                else if (r_run_gap == '0)      w_next = LAUNCH;
                else                           w_next = GAP;
            end
            GAP:   if (r_gap_cnt <= GAP_W'(1)) w_next = LAUNCH;
            DRAIN: if (w_pipe_idle_next) begin
                w_next     = IDLE;
                w_done_set = 1'b1;
            end
            default: w_next = IDLE;
        endcase
        // Abort outranks everything, including a completion in the same cycle.
        if (r_state != IDLE && bus.abort) begin
            w_next     = IDLE;
            w_done_set = 1'b0;
            w_abort_go = 1'b1;
        end
    end

    always_ff @(posedge clk_launch or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cfg_num <= '0;
            r_cfg_gap <= '0;
            r_cfg_src <= PG_IN;
            r_cfg_byp <= BYPASS;
            r_run_num <= '0;
            r_run_gap <= '0;
            r_pg_src  <= PG_IN;
            r_pg_byp  <= BYPASS;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_tog     <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_done    <= w_done_set;
            r_aborted <= w_abort_go;
            if (w_cfg_xfer) begin
                r_cfg_num <= bus.cfg_num;
                r_cfg_gap <= bus.cfg_gap;
                r_cfg_src <= bus.cfg_src;
                r_cfg_byp <= bus.cfg_bypass;
            end
            // A burst snapshots the previously latched config; a simultaneous offer waits for the next one.
            if (w_start_go) begin
                r_run_num <= r_cfg_num;
                r_run_gap <= r_cfg_gap;
                r_pg_src  <= r_cfg_src;
                r_pg_byp  <= r_cfg_byp;
                r_cnt     <= '0;
            end else if (w_cfg_xfer) begin
                r_pg_src  <= bus.cfg_src;
                r_pg_byp  <= bus.cfg_bypass;
            end
            if (w_launch) begin
                r_cnt     <= r_cnt + 1'b1;
                r_gap_cnt <= r_run_gap;
            end else if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            if (w_next == LAUNCH) r_tog <= ~r_tog;
        end
    end

    tdc_cap_delay #(.LAT(LAT)) u_cap_delay (
        .clk         (clk_launch),
        .rst_n       (rst_n),
        .i_clr       (w_abort_go),
        .i_in        (w_launch),
        .o_strobe    (w_strobe),
        .o_idle_next (w_pipe_idle_next)
    );

    assign bus.cfg_ready  = (r_state == IDLE);
    assign bus.pg_en      = w_launch;
    assign bus.pg_tog     = r_tog;
    assign bus.pg_src     = r_pg_src;
    assign bus.pg_bypass  = r_pg_byp;
    assign bus.cap_strobe = w_strobe;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.aborted    = r_aborted;
    assign bus.launch_cnt = r_cnt;
endmodule

// File: tb/tb_tdc_launch_ctrl.sv
// Directed bench for tdc_launch_ctrl: burst vector table plus hand-written corner sequences.
module tb_tdc_launch_ctrl;
    localparam int CAP_LAT = 3;

    typedef struct {
        int num; int gap; int src; int byp; int abort_at;
        int en;  int per; int str; int end_s; int ab; int cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_tog = 0;
    vec_t vecs[7];

    tdc_launch_ctrl_if #(.CNT_W(8), .GAP_W(8)) bus ();

    tdc_launch_ctrl #(.CNT_W(8), .GAP_W(8), .CAP_LAT(CAP_LAT)) dut (
        .clk_launch (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // All helpers start and end at a falling edge.
    task automatic cfg_xfer(input int num, input int gap, input int src, input int byp);
        bus.cfg_valid  = 1'b1;
        bus.cfg_num    = 8'(num);
        bus.cfg_gap    = 8'(gap);
        bus.cfg_src    = 1'(src);
        bus.cfg_bypass = 1'(byp);
        @(negedge clk);
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic cycles(input int n, output int en, output int st, output int dn, output int ab);
        en = 0; st = 0; dn = 0; ab = 0;
        for (int k = 0; k < n; k++) begin
            en += int'(bus.pg_en);
            st += int'(bus.cap_strobe);
            dn += int'(bus.done);
            ab += int'(bus.aborted);
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int en_n, st_n, dn_n, ab_n, end_s;
        en_n = 0; st_n = 0; dn_n = 0; ab_n = 0; end_s = -1;
        cfg_xfer(v.num, v.gap, v.src, v.byp);
        go();
        check($sformatf("v%0d busy_s0", idx), int'(bus.busy), int'(v.num != 0));
        check($sformatf("v%0d pg_src", idx), int'(bus.pg_src), v.src);
        check($sformatf("v%0d pg_bypass", idx), int'(bus.pg_bypass), v.byp);
        for (int s = 0; s < 200; s++) begin
            if (bus.pg_en) begin
                check($sformatf("v%0d en%0d_pos", idx, en_n), s, en_n * v.per);
                check($sformatf("v%0d en%0d_tog", idx, en_n), int'(bus.pg_tog), exp_tog ^ ((en_n + 1) & 1));
                en_n++;
            end
            if (bus.cap_strobe) begin
                check($sformatf("v%0d str%0d_pos", idx, st_n), s, st_n * v.per + CAP_LAT);
                st_n++;
            end
            dn_n += int'(bus.done);
            ab_n += int'(bus.aborted);
            if ((bus.done || bus.aborted) && end_s < 0) end_s = s;
            if (end_s >= 0 && s == end_s + 8) break;
            bus.abort = (s == v.abort_at);
            @(negedge clk);
        end
        bus.abort = 1'b0;
        check($sformatf("v%0d en_cnt", idx), en_n, v.en);
        check($sformatf("v%0d strobe_cnt", idx), st_n, v.str);
        check($sformatf("v%0d end_cycle", idx), end_s, v.end_s);
        check($sformatf("v%0d done_cnt", idx), dn_n, 1 - v.ab);
        check($sformatf("v%0d aborted_cnt", idx), ab_n, v.ab);
        check($sformatf("v%0d launch_cnt", idx), int'(bus.launch_cnt), v.cnt);
        check($sformatf("v%0d busy_end", idx), int'(bus.busy), 0);
        exp_tog ^= (v.en & 1);
        check($sformatf("v%0d tog_end", idx), int'(bus.pg_tog), exp_tog);
    endtask

    initial begin
        int en, st, dn, ab;
        //            num gap src byp abort  en per str end ab cnt
        vecs[0] = '{ 4,  2,  1,  1,  -1,    4,  3,  4, 13, 0, 4 };
        vecs[1] = '{ 3,  0,  0,  1,  -1,    3,  1,  3,  6, 0, 3 };
        vecs[2] = '{ 0,  3,  1,  0,  -1,    0,  1,  0,  0, 0, 0 };
        vecs[3] = '{ 8,  5,  0,  0,  13,    3,  6,  2, 14, 1, 3 };
        vecs[4] = '{ 1,  7,  1,  0,  -1,    1,  8,  1,  4, 0, 1 };
        vecs[5] = '{ 2,  1,  0,  1,  -1,    2,  2,  2,  6, 0, 2 };
        vecs[6] = '{ 3,  0,  1,  1,   1,    2,  1,  0,  2, 1, 2 };

        rst_n = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_num = '0; bus.cfg_gap = '0;
        bus.cfg_src = 1'b0; bus.cfg_bypass = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst pg_en", int'(bus.pg_en), 0);
        check("rst pg_tog", int'(bus.pg_tog), 0);
        check("rst pg_src", int'(bus.pg_src), 0);
        check("rst pg_bypass", int'(bus.pg_bypass), 0);
        check("rst cap_strobe", int'(bus.cap_strobe), 0);
        check("rst busy", int'(bus.busy), 0);
        check("rst done", int'(bus.done), 0);
        check("rst aborted", int'(bus.aborted), 0);
        check("rst launch_cnt", int'(bus.launch_cnt), 0);
        check("rst cfg_ready", int'(bus.cfg_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Config offered in the same cycle as start: burst runs the older config.
        cfg_xfer(1, 0, 0, 0);
        bus.cfg_valid = 1'b1; bus.cfg_num = 8'd3; bus.cfg_gap = 8'd0;
        bus.cfg_src = 1'b1; bus.cfg_bypass = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        check("same-cycle pg_src_old", int'(bus.pg_src), 0);
        cycles(10, en, st, dn, ab);
        check("same-cycle en_old", en, 1);
        check("same-cycle done", dn, 1);
        go();
        check("next-burst pg_src_new", int'(bus.pg_src), 1);
        cycles(12, en, st, dn, ab);
        check("next-burst en_new", en, 3);
        check("next-burst strobes", st, 3);

        // Offer held through a burst: refused while busy, taken once back in IDLE.
        cfg_xfer(2, 1, 0, 0);
        go();
        bus.cfg_valid = 1'b1; bus.cfg_num = 8'd5; bus.cfg_gap = 8'd0;
        bus.cfg_src = 1'b1; bus.cfg_bypass = 1'b1;
        check("held cfg_ready_busy", int'(bus.cfg_ready), 0);
        cycles(12, en, st, dn, ab);
        check("held en", en, 2);
        check("held done", dn, 1);
        check("held cfg_ready_idle", int'(bus.cfg_ready), 1);
        check("held pg_src_after", int'(bus.pg_src), 1);
        check("held pg_bypass_after", int'(bus.pg_bypass), 1);
        bus.cfg_valid = 1'b0;
        go();
        cycles(12, en, st, dn, ab);
        check("held-new en", en, 5);
        check("held-new done", dn, 1);
        check("held-new launch_cnt", int'(bus.launch_cnt), 5);

        // start and abort together in IDLE: nothing happens.
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("idle-abort busy", int'(bus.busy), 0);
        cycles(8, en, st, dn, ab);
        check("idle-abort en", en, 0);
        check("idle-abort done", dn, 0);
        check("idle-abort aborted", ab, 0);

        // Asynchronous reset in the middle of a back-to-back launch run.
        cfg_xfer(5, 0, 1, 1);
        go();
        @(negedge clk);
        @(negedge clk);
        check("pre-rst pg_en", int'(bus.pg_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async-rst pg_en", int'(bus.pg_en), 0);
        check("async-rst pg_tog", int'(bus.pg_tog), 0);
        check("async-rst pg_src", int'(bus.pg_src), 0);
        check("async-rst pg_bypass", int'(bus.pg_bypass), 0);
        check("async-rst busy", int'(bus.busy), 0);
        check("async-rst launch_cnt", int'(bus.launch_cnt), 0);
        check("async-rst cap_strobe", int'(bus.cap_strobe), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(10, en, st, dn, ab);
        check("post-rst en", en, 0);
        check("post-rst strobes", st, 0);
        check("post-rst done", dn, 0);
        check("post-rst aborted", ab, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
